// File: rtl/round_pack_stage.sv
// Two-stage round-and-pack into IEEE-754 single precision.
// Define ROUND_PACK_FLAGS_EN to add out_flags = {overflow, underflow, inexact}.
module round_pack_stage #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [23:0]      in_mant,
  input  logic             in_guard,
  input  logic             in_round,
  input  logic             in_sticky,
  input  logic [1:0]       in_rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ROUND_PACK_FLAGS_EN
  output logic [2:0]       out_flags,
`endif
  output logic [31:0]      out_result
);

  localparam logic signed [EXP_W:0] EXP_OVF = (EXP_W+1)'(255);
  localparam logic signed [EXP_W:0] EXP_UNF = '0;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [24:0]      s1_sum_q, s1_sum_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_inx_q, s1_inx_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      res_q, res_d;
  logic [2:0]       flags_q, flags_d;

  logic             s1_adv;
  logic             inexact;
  logic             rnd_up;

  assign s1_adv   = !s2_valid_q | out_ready;
  assign in_ready = !rst & (!s1_valid_q | s1_adv);
  assign inexact  = in_guard | in_round | in_sticky;

  always_comb begin
    rnd_up = 1'b0;
    unique case (in_rnd_mode)
      2'b00: rnd_up = 1'b0;
      2'b01: rnd_up = !in_sign & inexact;
      2'b10: rnd_up = in_sign & inexact;
      2'b11: rnd_up = in_guard & (in_mant[0] | in_round | in_sticky);
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mode_d  = s1_mode_q;
    s1_sum_d   = s1_sum_q;
    s1_zero_d  = s1_zero_q;
    s1_inx_d   = s1_inx_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_exp_d  = in_exp;
        s1_mode_d = in_rnd_mode;
        s1_sum_d  = {1'b0, in_mant} + 25'(rnd_up);
        s1_zero_d = (in_mant == 24'd0);
        s1_inx_d  = inexact;
      end
    end
  end

  logic signed [EXP_W:0] adj_exp;
  logic [22:0]           frac;
  logic                  to_inf;
  logic                  ovf;
  logic                  unf;
  logic [31:0]           pack;

  // Carry out of rounding renormalises by one place.
  assign adj_exp = $signed({s1_exp_q[EXP_W-1], s1_exp_q})
                 + $signed({{EXP_W{1'b0}}, s1_sum_q[24]});
  assign frac = s1_sum_q[24] ? s1_sum_q[23:1] : s1_sum_q[22:0];
  assign to_inf = (s1_mode_q == 2'b11)
                | ((s1_mode_q == 2'b01) & !s1_sign_q)
                | ((s1_mode_q == 2'b10) & s1_sign_q);

  always_comb begin
    ovf  = 1'b0;
    unf  = 1'b0;
    pack = {s1_sign_q, adj_exp[7:0], frac};
    if (s1_zero_q) begin
      pack = {s1_sign_q, 31'd0};
    end else if (adj_exp >= EXP_OVF) begin
      ovf  = 1'b1;
      pack = to_inf ? {s1_sign_q, 8'hFF, 23'd0}
                    : {s1_sign_q, 8'hFE, 23'h7FFFFF};
    end else if (adj_exp <= EXP_UNF) begin
      unf  = 1'b1;
      pack = {s1_sign_q, 31'd0};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    flags_d    = flags_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = pack;
        flags_d = {ovf, unf, s1_inx_q | ovf | unf};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_exp_q  <= s1_exp_d;
    s1_mode_q <= s1_mode_d;
    s1_sum_q  <= s1_sum_d;
    s1_zero_q <= s1_zero_d;
    s1_inx_q  <= s1_inx_d;
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;

`ifdef ROUND_PACK_FLAGS_EN
  assign out_flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_q;
`endif

endmodule

// File: tb/tb_round_pack_stage.sv
// Bench for round_pack_stage: directed cases, streaming with stalls,
// mid-flight reset, all against an arithmetic reference model.
module tb_round_pack_stage;

  typedef struct {
    logic        sign;
    int          exp;
    logic [23:0] mant;
    logic        g;
    logic        r;
    logic        st;
    logic [1:0]  mode;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [23:0] in_mant;
  logic        in_guard;
  logic        in_round;
  logic        in_sticky;
  logic [1:0]  in_rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int errors = 0;
  int checks = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  round_pack_stage #(.EXP_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .in_rnd_mode(in_rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(op_t o);
    in_sign     = o.sign;
    in_exp      = o.exp[9:0];
    in_mant     = o.mant;
    in_guard    = o.g;
    in_round    = o.r;
    in_sticky   = o.st;
    in_rnd_mode = o.mode;
  endtask

  function automatic logic [31:0] ref_model(op_t o);
    int     e;
    longint v;
    bit     inx;
    bit     up;
    bit     inf;
    logic [31:0] sgn;
    e   = o.exp;
    inx = o.g | o.r | o.st;
    sgn = o.sign ? 32'h8000_0000 : 32'h0;
    case (o.mode)
      2'd0: up = 0;
      2'd1: up = !o.sign && inx;
      2'd2: up = o.sign && inx;
      default: up = o.g && ((o.mant % 2) == 1 || o.r || o.st);
    endcase
    if (o.mant == 0) return sgn;
    v = longint'(o.mant) + longint'(up);
    if (v >= 64'd16777216) begin
      v = v / 2;
      e = e + 1;
    end
    if (e >= 255) begin
      inf = (o.mode == 3) || (o.mode == 1 && !o.sign) || (o.mode == 2 && o.sign);
      return sgn | (inf ? 32'h7F80_0000 : 32'h7F7F_FFFF);
    end
    if (e <= 0) return sgn;
    return sgn | 32'(e << 23) | 32'(v % 64'd8388608);
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    o.sign = 1'($urandom);
    k = int'($urandom_range(0, 9));
    if (k == 0)      o.exp = 254;
    else if (k == 1) o.exp = int'($urandom_range(0, 5)) - 3;
    else if (k == 2) o.exp = int'($urandom_range(255, 260));
    else             o.exp = int'($urandom_range(1, 253));
    k = int'($urandom_range(0, 9));
    if (k == 0)      o.mant = 24'd0;
    else if (k == 1) o.mant = 24'hFFFFFF;
    else             o.mant = {1'b1, 23'($urandom)};
    o.g    = 1'($urandom);
    o.r    = 1'($urandom);
    o.st   = 1'($urandom);
    o.mode = 2'($urandom);
    return o;
  endfunction

  task automatic run_one(string tag, op_t o, logic [31:0] want);
    drive(o);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_model"}, ref_model(o), want);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, out_result, want);
    tick();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic stream(string tag, int n, bit pattern);
    int  sent = 0;
    int  got = 0;
    int  cyc = 0;
    bit  have = 0;
    bit  stalled = 0;
    logic [31:0] held = '0;
    op_t cur;
    bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while ((sent < n || expq.size() > 0) && cyc < 2000) begin
      out_ready = pattern ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
      if (!have && sent < n && (pattern || $urandom_range(0, 4) != 0)) begin
        cur  = rand_op();
        have = 1;
      end
      in_valid = have;
      if (have) drive(cur);
      #1;
      if (stalled) check({tag, "_stall_hold"}, out_result, held);
      if (out_valid && expq.size() == 0)
        check({tag, "_spurious_valid"}, 32'(out_valid), 32'd0);
      if (out_valid && out_ready && expq.size() > 0) begin
        check({tag, "_data"}, out_result, expq.pop_front());
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_result;
      if (in_valid && in_ready) begin
        expq.push_back(ref_model(cur));
        sent++;
        have = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_budget"}, 32'(cyc < 2000), 32'd1);
  endtask

  initial begin
    op_t o;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    o = '{sign: 0, exp: 1, mant: 24'h800000, g: 0, r: 0, st: 0, mode: 0};
    drive(o);
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    tick();

    o = '{sign: 0, exp: 127, mant: 24'hC00000, g: 0, r: 0, st: 0, mode: 3};
    run_one("plain", o, 32'h3FC0_0000);
    o = '{sign: 0, exp: 127, mant: 24'hFFFFFF, g: 1, r: 0, st: 0, mode: 3};
    run_one("carry", o, 32'h4000_0000);
    o = '{sign: 1, exp: 254, mant: 24'hFFFFFF, g: 1, r: 0, st: 0, mode: 2};
    run_one("ovf_inf", o, 32'hFF80_0000);
    o = '{sign: 1, exp: 254, mant: 24'hFFFFFF, g: 1, r: 0, st: 0, mode: 1};
    run_one("ovf_max", o, 32'hFF7F_FFFF);
    o = '{sign: 0, exp: 254, mant: 24'hFFFFFF, g: 1, r: 0, st: 0, mode: 0};
    run_one("ovf_trunc", o, 32'h7F7F_FFFF);
    o = '{sign: 0, exp: 300, mant: 24'h800000, g: 0, r: 0, st: 0, mode: 0};
    run_one("ovf_big", o, 32'h7F7F_FFFF);
    o = '{sign: 0, exp: 0, mant: 24'h800000, g: 0, r: 0, st: 0, mode: 0};
    run_one("unf", o, 32'h0000_0000);
    o = '{sign: 1, exp: -4, mant: 24'hABCDEF, g: 1, r: 1, st: 1, mode: 3};
    run_one("unf_neg", o, 32'h8000_0000);
    o = '{sign: 1, exp: 100, mant: 24'h000000, g: 1, r: 1, st: 1, mode: 2};
    run_one("zero", o, 32'h8000_0000);
    o = '{sign: 0, exp: 1, mant: 24'h800001, g: 1, r: 0, st: 0, mode: 3};
    run_one("tie_odd", o, 32'h0080_0002);
    o = '{sign: 0, exp: 1, mant: 24'h800002, g: 1, r: 0, st: 0, mode: 3};
    run_one("tie_even", o, 32'h0080_0002);

    stream("burst8", 8, 1'b1);
    stream("rand", 300, 1'b0);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(rand_op());
    tick();
    drive(rand_op());
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready_rel", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
